// File: rtl/cpu_param_multicycle_if.sv
// ----------------------------------------------------------------------------
// cpu_param_multicycle_if
// Bus bundle for the parametrised multicycle CPU core.
//   Program loader : RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data
//   Run control    : PC_Enable
//   Input port     : InD, InE
//   Observation    : OutD, PC, PI, Halted, REG_flat (R3..R0), RAM_flat (word 0 in LSBs)
// The master modport drives the loader/run/input signals; the slave (the
// core) drives the observation outputs.
// ----------------------------------------------------------------------------
interface cpu_param_multicycle_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  localparam int INSTR_W = 8 + ADDR_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  logic                     PC_Enable;
  logic                     RAM_Write_Enable;
  logic [ADDR_W-1:0]        RAM_Write_Address;
  logic [INSTR_W-1:0]       RAM_Write_Data;
  logic [DATA_W-1:0]        InD;
  logic                     InE;
  logic [DATA_W-1:0]        OutD;
  logic [ADDR_W-1:0]        PC;
  logic [INSTR_W-1:0]       PI;
  logic                     Halted;
  logic [4*DATA_W-1:0]      REG_flat;
  logic [DEPTH*INSTR_W-1:0] RAM_flat;

  modport master (
    output PC_Enable, RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data, InD, InE,
    input  OutD, PC, PI, Halted, REG_flat, RAM_flat
  );

  modport slave (
    input  PC_Enable, RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data, InD, InE,
    output OutD, PC, PI, Halted, REG_flat, RAM_flat
  );
endinterface

// File: rtl/cpu_param_multicycle.sv
// ----------------------------------------------------------------------------
// cpu_param_multicycle
// Multicycle 4-register CPU with a unified instruction/data RAM that can be
// loaded externally. FETCH latches RAM[PC] into PI, EXEC performs the
// instruction and updates PC, MEM completes LD/ST, HALT is terminal.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; RAM contents are kept
//   bus    : cpu_param_multicycle_if.slave (loader, run enable, I/O, observation)
// Instruction word: op[INSTR_W-1 -: 4] rd[2] rs[2] imm[ADDR_W]
// Build option: define CPU_IN_WAIT_EN to make IN stall in WAIT_IN until InE=1;
// without it IN samples InD in EXEC unconditionally.
// ----------------------------------------------------------------------------
module cpu_param_multicycle #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_param_multicycle_if.slave bus
);
  localparam int INSTR_W = 8 + ADDR_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_EXEC    = 3'd1;
  localparam logic [2:0] S_MEM     = 3'd2;
  localparam logic [2:0] S_HALT    = 3'd3;
`ifdef CPU_IN_WAIT_EN
  localparam logic [2:0] S_WAIT_IN = 3'd4;
`endif

  localparam logic [3:0] OP_LDI = 4'h1, OP_LD  = 4'h2, OP_JG  = 4'h3, OP_JE   = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5, OP_ROL = 4'h6, OP_ST  = 4'h7, OP_CMP  = 4'h8;
  localparam logic [3:0] OP_SUB = 4'h9, OP_MOV = 4'hA, OP_ADD = 4'hB, OP_AND  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD, OP_IN  = 4'hE, OP_HALT = 4'hF;

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_pi;
  logic [DATA_W-1:0]  r_regs [4];
  logic               r_g, r_e, r_halted;
  logic [DATA_W-1:0]  r_outd;
  logic [INSTR_W-1:0] r_ram [DEPTH];

  // Decode of the latched instruction
  logic [3:0]        w_op;
  logic [1:0]        w_rd, w_rs;
  logic [ADDR_W-1:0] w_imm;
  assign w_op  = r_pi[INSTR_W-1 -: 4];
  assign w_rd  = r_pi[INSTR_W-5 -: 2];
  assign w_rs  = r_pi[INSTR_W-7 -: 2];
  assign w_imm = r_pi[ADDR_W-1:0];

  logic [DATA_W-1:0]  w_rd_val, w_rs_val, w_imm_data, w_ld_data, w_rol;
  logic [ADDR_W-1:0]  w_mem_addr, w_pc_inc;
  logic [INSTR_W-1:0] w_st_data;
  logic [31:0]        w_rot_amt;

  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_pc_inc = r_pc + 1'b1;   // wraps DEPTH-1 -> 0

  // Width adaptation between data, address and instruction words
  generate
    if (DATA_W >= ADDR_W) begin : g_addr_trunc
      assign w_mem_addr = w_rs_val[ADDR_W-1:0];
    end else begin : g_addr_zext
      assign w_mem_addr = ADDR_W'(w_rs_val);
    end
    if (DATA_W > ADDR_W) begin : g_imm_zext
      assign w_imm_data = DATA_W'(w_imm);
    end else begin : g_imm_trunc
      assign w_imm_data = w_imm[DATA_W-1:0];
    end
    if (INSTR_W >= DATA_W) begin : g_ld_trunc
      assign w_ld_data = r_ram[w_mem_addr][DATA_W-1:0];
    end else begin : g_ld_zext
      assign w_ld_data = DATA_W'(r_ram[w_mem_addr]);
    end
    if (DATA_W >= INSTR_W) begin : g_st_trunc
      assign w_st_data = w_rd_val[INSTR_W-1:0];
    end else begin : g_st_zext
      assign w_st_data = INSTR_W'(w_rd_val);
    end
  endgenerate

  // Rotate via a doubled word: the upper half of {v,v}<<n is v rotated left by n
  assign w_rot_amt = 32'(w_imm) % 32'(DATA_W);
  assign w_rol     = DATA_W'(({w_rd_val, w_rd_val} << w_rot_amt) >> DATA_W);

  logic [2:0]         w_state_next;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [INSTR_W-1:0] w_pi_next;
  logic               w_g_next, w_e_next, w_halted_next;
  logic [DATA_W-1:0]  w_outd_next, w_reg_wd;
  logic               w_reg_we, w_ram_we;
  logic [ADDR_W-1:0]  w_ram_wa;
  logic [INSTR_W-1:0] w_ram_wd;

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_pi_next     = r_pi;
    w_g_next      = r_g;
    w_e_next      = r_e;
    w_outd_next   = r_outd;
    w_halted_next = r_halted;
    w_reg_we      = 1'b0;
    w_reg_wd      = w_rd_val;
    w_ram_we      = 1'b0;
    w_ram_wa      = w_mem_addr;
    w_ram_wd      = w_st_data;
    // The loader owns the single RAM write port; the FSM simply waits a cycle.
    if (bus.RAM_Write_Enable) begin
      w_ram_we = 1'b1;
      w_ram_wa = bus.RAM_Write_Address;
      w_ram_wd = bus.RAM_Write_Data;
    end else if (bus.PC_Enable && !reset) begin
      case (r_state)
        S_FETCH: begin
          w_pi_next    = r_ram[r_pc];
          w_state_next = S_EXEC;
        end
        S_EXEC: begin
          w_pc_next    = w_pc_inc;
          w_state_next = S_FETCH;
          case (w_op)
            OP_LDI: begin w_reg_we = 1'b1; w_reg_wd = w_imm_data; end
            OP_LD, OP_ST: w_state_next = S_MEM;
            OP_JG:  if (r_g) w_pc_next = w_imm;
            OP_JE:  if (r_e) w_pc_next = w_imm;
            OP_JMP: w_pc_next = w_imm;
            OP_ROL: begin w_reg_we = 1'b1; w_reg_wd = w_rol; end
            OP_CMP: begin
              w_g_next = (w_rd_val > w_rs_val);
              w_e_next = (w_rd_val == w_rs_val);
            end
            OP_SUB: begin w_reg_we = 1'b1; w_reg_wd = w_rd_val - w_rs_val; end
            OP_MOV: begin w_reg_we = 1'b1; w_reg_wd = w_rs_val; end
            OP_ADD: begin w_reg_we = 1'b1; w_reg_wd = w_rd_val + w_rs_val; end
            OP_AND: begin w_reg_we = 1'b1; w_reg_wd = w_rd_val & w_rs_val; end
            OP_OUT: w_outd_next = w_rs_val;
            OP_IN: begin
`ifdef CPU_IN_WAIT_EN
              if (bus.InE) begin
                w_reg_we = 1'b1;
                w_reg_wd = bus.InD;
              end else begin
                w_pc_next    = r_pc;   // PC advances only once the input arrives
                w_state_next = S_WAIT_IN;
              end
`else
              w_reg_we = 1'b1;
              w_reg_wd = bus.InD;
`endif
            end
            OP_HALT: begin
              w_halted_next = 1'b1;
              w_state_next  = S_HALT;
            end
            default: ;  // NOP
          endcase
        end
        S_MEM: begin
          w_state_next = S_FETCH;
          if (w_op == OP_LD) begin
            w_reg_we = 1'b1;
            w_reg_wd = w_ld_data;
          end else begin
            w_ram_we = 1'b1;
          end
        end
`ifdef CPU_IN_WAIT_EN
        S_WAIT_IN: begin
          if (bus.InE) begin
            w_reg_we     = 1'b1;
            w_reg_wd     = bus.InD;
            w_pc_next    = w_pc_inc;
            w_state_next = S_FETCH;
          end
        end
`endif
        default: ;  // S_HALT: terminal until reset
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_pi     <= '0;
      r_g      <= 1'b0;
      r_e      <= 1'b0;
      r_outd   <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_pi     <= w_pi_next;
      r_g      <= w_g_next;
      r_e      <= w_e_next;
      r_outd   <= w_outd_next;
      r_halted <= w_halted_next;
      if (w_reg_we) r_regs[w_rd] <= w_reg_wd;
    end
  end

  // RAM is deliberately outside reset so loaded programs survive it
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_wa] <= w_ram_wd;
  end

  assign bus.OutD   = r_outd;
  assign bus.PC     = r_pc;
  assign bus.PI     = r_pi;
  assign bus.Halted = r_halted;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg_flat
      assign bus.REG_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ram_flat
      assign bus.RAM_flat[gi*INSTR_W +: INSTR_W] = r_ram[gi];
    end
  endgenerate
endmodule

// File: tb/tb_cpu_param_multicycle.sv
module tb_cpu_param_multicycle;
  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_param_multicycle_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  cpu_param_multicycle #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [10:0] enc(input int op, input int rd, input int rs, input int imm);
    return {4'(op), 2'(rd), 2'(rs), 3'(imm)};
  endfunction

  // ---------------- instruction-level reference model ----------------
  logic [7:0]  m_r [4];
  logic [10:0] m_ram [8];
  logic [2:0]  m_pc;
  logic [10:0] m_ir;
  logic        m_g, m_e, m_halt;
  logic [7:0]  m_out;
  int          m_cyc = 0;
  bit          m_chk = 0;
  bit          chk_en = 0;

  task automatic m_exec();
    int op, rd, rs, imm, a, b, n;
    op = int'(m_ir[10:7]); rd = int'(m_ir[6:5]); rs = int'(m_ir[4:3]); imm = int'(m_ir[2:0]);
    a = int'(m_r[rd]); b = int'(m_r[rs]);
    m_pc = 3'((int'(m_pc) + 1) % 8);
    case (op)
      1:  m_r[rd] = 8'(imm);
      2:  m_r[rd] = 8'(int'(m_ram[b % 8]) % 256);
      3:  if (m_g) m_pc = 3'(imm);
      4:  if (m_e) m_pc = 3'(imm);
      5:  m_pc = 3'(imm);
      6:  begin n = imm % 8; m_r[rd] = 8'((a * (1 << n) + a / (1 << (8 - n))) % 256); end
      7:  m_ram[b % 8] = 11'(a);
      8:  begin m_g = (a > b); m_e = (a == b); end
      9:  m_r[rd] = 8'((a - b + 256) % 256);
      10: m_r[rd] = 8'(b);
      11: m_r[rd] = 8'((a + b) % 256);
      12: m_r[rd] = 8'(a & b);
      13: m_out = 8'(b);
      14: m_r[rd] = bus.InD;
      15: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    bit ld, fin;
    int op;
    ld = bus.RAM_Write_Enable;
    fin = 0;
    m_chk = 0;
    if (ld) m_ram[bus.RAM_Write_Address] = bus.RAM_Write_Data;
    if (reset) begin
      m_pc = '0; m_ir = '0; m_g = 0; m_e = 0; m_halt = 0; m_out = '0; m_cyc = 0;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
      m_chk = 1;
    end else if (!ld && bus.PC_Enable && !m_halt) begin
      m_cyc++;
      if (m_cyc == 1) m_ir = m_ram[m_pc];
      else begin
        op = int'(m_ir[10:7]);
        if (op == 2 || op == 7) fin = (m_cyc == 3);
`ifdef CPU_IN_WAIT_EN
        else if (op == 14) fin = bus.InE;
`endif
        else fin = 1;
        if (fin) begin
          m_exec();
          m_cyc = 0;
          m_chk = 1;
        end
      end
    end
  end

  // Compare at every instruction boundary and after every reset cycle
  always @(negedge clk) begin
    logic [87:0] ram_exp;
    if (chk_en && m_chk) begin
      for (int i = 0; i < 8; i++) ram_exp[i*11 +: 11] = m_ram[i];
      check("pc",     128'(bus.PC),       128'(m_pc));
      check("pi",     128'(bus.PI),       128'(m_ir));
      check("regs",   128'(bus.REG_flat), 128'({m_r[3], m_r[2], m_r[1], m_r[0]}));
      check("outd",   128'(bus.OutD),     128'(m_out));
      check("halted", 128'(bus.Halted),   128'(m_halt));
      check("ram",    128'(bus.RAM_flat), 128'(ram_exp));
    end
  end

  // ---------------- stimulus ----------------
  logic [10:0] prog [8];

  task automatic load(input logic [2:0] a, input logic [10:0] d);
    bus.RAM_Write_Enable  = 1'b1;
    bus.RAM_Write_Address = a;
    bus.RAM_Write_Data    = d;
    @(negedge clk);
    bus.RAM_Write_Enable  = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 8; i++) load(3'(i), prog[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    bus.PC_Enable = 1'b1;
    repeat (n) @(negedge clk);
    bus.PC_Enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.PC_Enable = 1'b0; bus.RAM_Write_Enable = 1'b0;
    bus.RAM_Write_Address = '0; bus.RAM_Write_Data = '0;
    bus.InD = '0; bus.InE = 1'b1;
    for (int i = 0; i < 8; i++) load(3'(i), 11'd0);
    chk_en = 1;
    do_reset();
    check("rst_pc",   128'(bus.PC), 128'(0));
    check("rst_pi",   128'(bus.PI), 128'(0));
    check("rst_regs", 128'(bus.REG_flat), 128'(0));
    check("rst_halt", 128'(bus.Halted), 128'(0));

    // 1: LDI R2,7; LD R1,[R2]; HALT with RAM[7]=3
    prog = '{enc(1,2,0,7), enc(2,1,2,0), enc(15,0,0,0), 11'd0, 11'd0, 11'd0, 11'd0, 11'd3};
    load_prog(); do_reset(); run(7);
    check("t1_r1",   128'(bus.REG_flat[15:8]), 128'(3));
    check("t1_halt", 128'(bus.Halted), 128'(1));
    check("t1_pc",   128'(bus.PC), 128'(3));
    run(3);
    check("t1_pc_frozen", 128'(bus.PC), 128'(3));

    // 2: LDI R0,7; ROL R0,2; loop ADD R0,R0 until it wraps to 0
    prog = '{enc(1,0,0,7), enc(6,0,0,2), enc(11,0,0,0), enc(5,0,0,2), 11'd0, 11'd0, 11'd0, 11'd0};
    load_prog(); do_reset(); run(4);
    check("t2_rol", 128'(bus.REG_flat[7:0]), 128'(8'h1C));
    run(22);
    check("t2_wrap", 128'(bus.REG_flat[7:0]), 128'(0));
    run(3);
    do_reset();
    check("t2_midrst_pc", 128'(bus.PC), 128'(0));

    // 3: count R0 up to R1 with CMP/JG, then OUT and JE self-loop
    prog = '{enc(1,0,0,1), enc(1,1,0,3), enc(1,2,0,1), enc(11,0,2,0),
             enc(8,1,0,0), enc(3,0,0,3), enc(13,0,0,0), enc(4,0,0,7)};
    load_prog(); do_reset(); run(26);
    check("t3_r0",   128'(bus.REG_flat[7:0]), 128'(3));
    check("t3_outd", 128'(bus.OutD), 128'(3));
    check("t3_pc",   128'(bus.PC), 128'(7));

    // 4: ROL corner cases and ST with truncation/extension
    bus.InD = 8'h81; bus.InE = 1'b1;
    prog = '{enc(14,0,0,0), enc(6,0,0,2), enc(13,0,0,0), enc(6,0,0,0),
             enc(6,0,0,7), enc(13,0,0,0), enc(7,0,1,0), enc(15,0,0,0)};
    load_prog(); do_reset(); run(6);
    check("t4_rol2", 128'(bus.OutD), 128'(8'h06));
    run(2);
    check("t4_rol0", 128'(bus.REG_flat[7:0]), 128'(8'h06));
    run(2);
    check("t4_rol7", 128'(bus.REG_flat[7:0]), 128'(8'h03));
    run(10);
    check("t4_st",   128'(bus.RAM_flat[10:0]), 128'(3));
    check("t4_halt", 128'(bus.Halted), 128'(1));

    // 5: NOP sweep with PC wrap, freeze, and loader write while running
    prog = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
    load_prog(); do_reset(); run(16);
    check("t5_wrap", 128'(bus.PC), 128'(0));
    run(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_frozen", 128'(bus.PC), 128'(0));
    end
    run(1);
    check("t5_resume", 128'(bus.PC), 128'(1));
    bus.PC_Enable = 1'b1;
    load(3'd1, enc(1,3,0,5));
    check("t5_stall", 128'(bus.PC), 128'(1));
    repeat (2) @(negedge clk);
    bus.PC_Enable = 1'b0;
    check("t5_newfetch_r3", 128'(bus.REG_flat[31:24]), 128'(5));
    check("t5_newfetch_pc", 128'(bus.PC), 128'(2));

    // 6: IN R3 with InE low
    prog = '{enc(14,3,0,0), enc(15,0,0,0), 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
    load_prog(); bus.InE = 1'b0; do_reset();
`ifdef CPU_IN_WAIT_EN
    bus.InD = 8'd9;
    run(6);
    check("t6_pc_held", 128'(bus.PC), 128'(0));
    bus.InD = 8'd5; bus.InE = 1'b1;
    run(1);
`else
    bus.InD = 8'd5;
    run(2);
`endif
    check("t6_r3", 128'(bus.REG_flat[31:24]), 128'(5));
    check("t6_pc", 128'(bus.PC), 128'(1));
    run(2);
    check("t6_halt", 128'(bus.Halted), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
